// File: rtl/demod_ctrl_pkg.sv
// Shared types and constants for the IQ demodulator LO sequencer.
// Holds the ternary LO table, phase steps and the sequencer state type.
package demod_ctrl_pkg;

    typedef logic signed [1:0] lo_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } demod_ctrl_state_e;

    // Ternary quadrature table indexed by phase 0..7 (45 deg per index)
    localparam lo_t LO_COS [8] = '{
        2'b01, 2'b01, 2'b00, 2'b11,
        2'b11, 2'b11, 2'b00, 2'b01
    };
    localparam lo_t LO_SIN [8] = '{
        2'b00, 2'b01, 2'b01, 2'b01,
        2'b00, 2'b11, 2'b11, 2'b11
    };

    localparam logic [2:0] STEP_FS4 = 3'd2;
    localparam logic [2:0] STEP_FS8 = 3'd1;

endpackage

// File: rtl/demod_lo_rom.sv
// Combinational phase -> (sin, cos) lookup for the ternary LO.
// Never produces -2; table holds only -1, 0, +1.
module demod_lo_rom
    import demod_ctrl_pkg::*;
(
    input  logic [2:0] phase_i,
    output lo_t        sin_o,
    output lo_t        cos_o
);

    assign sin_o = LO_SIN[phase_i];
    assign cos_o = LO_COS[phase_i];

endmodule

// File: rtl/demod_lo_ctrl.sv
// LO sequencer: burst control, settle discard, phase accumulation
// and registered LO / strobe outputs for the IQ demodulator.
module demod_lo_ctrl
    import demod_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [2:0]       phase_init,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             ADC_rdy,
    output lo_t              sine_out,
    output lo_t              cosine_out,
    output logic             adc_rdy_q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int SW = $clog2(SETTLE + 1);

    demod_ctrl_state_e state_q, state_d;
    logic              mode_q, mode_d;
    logic [2:0]        pinit_q, pinit_d;
    logic [CNT_W-1:0]  blen_q, blen_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [2:0]        phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lo_t               sin_q, sin_d;
    lo_t               cos_q, cos_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;

    lo_t               rom_sin;
    lo_t               rom_cos;
    logic [2:0]        step;
    logic [CNT_W-1:0]  cnt_inc;

    demod_lo_rom u_rom (
        .phase_i (phase_q),
        .sin_o   (rom_sin),
        .cos_o   (rom_cos)
    );

    assign step    = mode_q ? STEP_FS8 : STEP_FS4;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, config latch, counters and output values
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        pinit_d  = pinit_q;
        blen_d   = blen_q;
        settle_d = settle_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        sin_d    = sin_q;
        cos_d    = cos_q;
        rdy_d    = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sin_d = '0;
                cos_d = '0;
                if (start && !stop) begin
                    state_d  = ST_SETTLE;
                    mode_d   = mode;
                    pinit_d  = phase_init;
                    blen_d   = burst_len;
                    cnt_d    = '0;
                    settle_d = SW'(SETTLE);
                end
            end
            ST_SETTLE: begin
                sin_d = '0;
                cos_d = '0;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (ADC_rdy) begin
                    settle_d = settle_q - SW'(1);
                    if (settle_q == SW'(1)) begin
                        state_d = ST_RUN;
                        phase_d = pinit_q;
                    end
                end
            end
            ST_RUN: begin
                // done_q marks the cycle after the last sample: leave then
                if (stop || done_q) begin
                    state_d = ST_IDLE;
                    sin_d   = '0;
                    cos_d   = '0;
                end else if (ADC_rdy) begin
                    sin_d   = rom_sin;
                    cos_d   = rom_cos;
                    rdy_d   = 1'b1;
                    phase_d = phase_q + step;
                    cnt_d   = cnt_inc;
                    if (blen_q != '0 && cnt_inc == blen_q) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sin_d   = '0;
                cos_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            pinit_q  <= '0;
            blen_q   <= '0;
            settle_q <= '0;
            phase_q  <= '0;
            cnt_q    <= '0;
            sin_q    <= '0;
            cos_q    <= '0;
            rdy_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            pinit_q  <= pinit_d;
            blen_q   <= blen_d;
            settle_q <= settle_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            sin_q    <= sin_d;
            cos_q    <= cos_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
        end
    end

    assign sine_out   = sin_q;
    assign cosine_out = cos_q;
    assign adc_rdy_q  = rdy_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign sample_cnt = cnt_q;

endmodule
